// File: rtl/fadd_sequencer.sv
// Initiator-side sequencer for one bf16 fadd instance: it takes in an operand pair, waits for a fresh ready edge, and holds the sum.
// Optional watchdog: define FADD_SEQ_TIMEOUT_EN to turn on the WAIT-state timeout, which returns a bf16 qNaN.
module fadd_sequencer #(
  parameter int unsigned GUARD_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic [15:0] a,
  output logic [15:0] b,
  input  logic        fadd_ready,
  input  logic [15:0] fadd_sum,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_sum,
  output logic        busy,
  output logic        err_timeout,
  output logic [15:0] done_count
);

  localparam int unsigned GW = $clog2(GUARD_CYCLES + 1);

  if (GUARD_CYCLES < 1) begin : g_bad_guard
    $error("GUARD_CYCLES must be >= 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_e;

  state_e          state_q, state_d;
  logic [15:0]     a_q, a_d;
  logic [15:0]     b_q, b_d;
  logic [15:0]     res_sum_q, res_sum_d;
  logic [15:0]     done_q, done_d;
  logic [GW-1:0]   guard_q, guard_d;
  logic            ready_q, ready_d;
  logic            rise;

`ifdef FADD_SEQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            err_q, err_d;
`endif

  // A sum counts only when ready rises; a level left over from the previous operands is ignored.
  assign rise = fadd_ready & ~ready_q;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_sum_d = res_sum_q;
    done_d    = done_q;
    guard_d   = guard_q;
    ready_d   = fadd_ready;
`ifdef FADD_SEQ_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (op_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          guard_d = GW'(GUARD_CYCLES);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (guard_q == GW'(1)) begin
          state_d = WAIT;
`ifdef FADD_SEQ_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end else begin
          guard_d = guard_q - GW'(1);
        end
      end
      WAIT: begin
        if (rise) begin
          res_sum_d = fadd_sum;
          state_d   = HOLD;
        end
`ifdef FADD_SEQ_TIMEOUT_EN
        else if (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          res_sum_d = 16'h7FC0;
          err_d     = 1'b1;
          state_d   = HOLD;
        end else begin
          wait_cnt_d = wait_cnt_q + TW'(1);
        end
`endif
      end
      HOLD: begin
        if (res_ready) begin
          done_d  = done_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      res_sum_q <= '0;
      done_q    <= '0;
      guard_q   <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_sum_q <= res_sum_d;
      done_q    <= done_d;
      guard_q   <= guard_d;
      ready_q   <= ready_d;
    end
  end

`ifdef FADD_SEQ_TIMEOUT_EN
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign op_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign res_valid  = (state_q == HOLD);
  assign a          = a_q;
  assign b          = b_q;
  assign res_sum    = res_sum_q;
  assign done_count = done_q;

endmodule
